// File: rtl/pattern_scan_controller_if.sv
// Start/abort handshake and status bundle between a word producer and
// the pattern scan controller.
interface pattern_scan_controller_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       pattern;
  logic             abort;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             done;

  modport master (
    output start_valid, data_in, pattern, abort,
    input  start_ready, busy, match_pulse, match_count, done
  );

  modport slave (
    input  start_valid, data_in, pattern, abort,
    output start_ready, busy, match_pulse, match_count, done
  );
endinterface

// File: rtl/pattern_scan_controller.sv
// Shifts an accepted word MSB-first through an overlapping 4-bit Mealy
// detector, counting matches and pulsing done when the last bit is consumed.
module pattern_scan_controller #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic                    CLK,
  input logic                    RESET,
  pattern_scan_controller_if.slave bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [3:0]       pattern_reg;
  logic [2:0]       hist_reg;
  logic [1:0]       vcnt_reg;
  logic [IDX_W-1:0] bit_idx_reg;
  logic [CNT_W-1:0] match_count_reg;

  logic cur_bit;
  logic match_now;
  logic last_bit;

  assign cur_bit  = shreg_reg[WIDTH-1];
  // vcnt gate keeps the zero-initialised history from faking early matches
  assign match_now = (state_reg == SCAN) && (vcnt_reg == 2'd3) &&
                     ({hist_reg, cur_bit} == pattern_reg);
  assign last_bit  = (bit_idx_reg == IDX_W'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      pattern_reg     <= '0;
      hist_reg        <= '0;
      vcnt_reg        <= '0;
      bit_idx_reg     <= '0;
      match_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_valid) begin
            shreg_reg       <= bus.data_in;
            pattern_reg     <= bus.pattern;
            hist_reg        <= '0;
            vcnt_reg        <= '0;
            bit_idx_reg     <= '0;
            match_count_reg <= '0;
            state_reg       <= SCAN;
          end
        end
        SCAN: begin
          if (bus.abort) begin
            match_count_reg <= '0;
            state_reg       <= IDLE;
          end else begin
            hist_reg    <= {hist_reg[1:0], cur_bit};
            shreg_reg   <= {shreg_reg[WIDTH-2:0], 1'b0};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (vcnt_reg != 2'd3)
              vcnt_reg <= vcnt_reg + 2'd1;
            if (match_now)
              match_count_reg <= match_count_reg + 1'b1;
            if (last_bit)
              state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state_reg == IDLE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = (state_reg == DONE);
  assign bus.match_pulse = match_now;
  assign bus.match_count = match_count_reg;
endmodule

// File: tb/tb_pattern_scan_controller.sv
// Directed and randomized scans of pattern_scan_controller checked against a
// window-comparison model of the MSB-first pattern search.
module tb_pattern_scan_controller;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic CLK;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  pattern_scan_controller_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pattern_scan_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit j in time is d[WIDTH-1-j]; scan cycle i (i>=3) matches
  // when the four most recent bits j=i-3..i, oldest first, equal the pattern.
  function automatic void model(input logic [WIDTH-1:0] d, input logic [3:0] p,
                                output logic [WIDTH-1:0] mask, output int cnt);
    logic [3:0] w;
    mask = '0;
    cnt  = 0;
    for (int i = 3; i < WIDTH; i++) begin
      w = {d[WIDTH+2-i], d[WIDTH+1-i], d[WIDTH-i], d[WIDTH-1-i]};
      if (w == p) begin
        mask[i] = 1'b1;
        cnt++;
      end
    end
  endfunction

  // Starts at a negedge with the DUT idle and returns at a negedge in IDLE.
  task automatic run_scan(input logic [WIDTH-1:0] d, input logic [3:0] p,
                          input int abort_at, input bit noise);
    logic [WIDTH-1:0] mask;
    int cnt;
    int run;
    model(d, p, mask, cnt);
    chk("ready_before_accept", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.data_in     = d;
    bus.pattern     = p;
    @(negedge CLK);
    bus.start_valid = 1'b0;
    bus.data_in     = WIDTH'($urandom);
    bus.pattern     = 4'($urandom);
    run = 0;
    for (int i = 0; i < WIDTH; i++) begin
      chk($sformatf("match_pulse_c%0d", i), 32'(bus.match_pulse), 32'(mask[i]));
      chk("busy_scan", 32'(bus.busy), 32'd1);
      chk("ready_scan", 32'(bus.start_ready), 32'd0);
      chk("done_scan", 32'(bus.done), 32'd0);
      chk($sformatf("running_count_c%0d", i), 32'(bus.match_count), 32'(run));
      if (mask[i]) run++;
      if (noise) begin
        bus.start_valid = 1'($urandom_range(0, 1));
        bus.data_in     = WIDTH'($urandom);
        bus.pattern     = 4'($urandom);
      end
      if (i == abort_at) begin
        bus.abort = 1'b1;
        @(negedge CLK);
        bus.abort       = 1'b0;
        bus.start_valid = 1'b0;
        chk("abort_ready", 32'(bus.start_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_count", 32'(bus.match_count), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        $display("scan data=%h pat=%b aborted at cycle %0d", d, p, i);
        return;
      end
      @(negedge CLK);
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd1);
    chk("ready_done", 32'(bus.start_ready), 32'd0);
    chk("match_pulse_done", 32'(bus.match_pulse), 32'd0);
    chk("final_count", 32'(bus.match_count), 32'(cnt));
    if (noise) bus.start_valid = 1'b1;
    @(negedge CLK);
    bus.start_valid = 1'b0;
    chk("done_cleared", 32'(bus.done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("ready_idle", 32'(bus.start_ready), 32'd1);
    chk("count_hold", 32'(bus.match_count), 32'(cnt));
    $display("scan data=%h pat=%b count=%0d expected=%0d", d, p, bus.match_count, cnt);
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    logic [3:0]       rp;
    int               ab;
    RESET           = 1'b1;
    bus.start_valid = 1'b0;
    bus.data_in     = '0;
    bus.pattern     = '0;
    bus.abort       = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("reset_ready", 32'(bus.start_ready), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_match", 32'(bus.match_pulse), 32'd0);
    chk("reset_count", 32'(bus.match_count), 32'd0);

    run_scan(16'hD000, 4'b1101, -1, 1'b0);
    run_scan(16'b1101101101101101, 4'b1101, -1, 1'b0);
    run_scan(16'h0000, 4'b0000, -1, 1'b0);
    run_scan(16'hFFFF, 4'b1111, 5, 1'b0);
    run_scan(16'hD000, 4'b1101, -1, 1'b0);
    run_scan(16'hB6DB, 4'b1011, -1, 1'b1);

    // Reset mid-scan, with abort and start_valid also high, must win.
    bus.start_valid = 1'b1;
    bus.data_in     = 16'hFFFF;
    bus.pattern     = 4'b1111;
    @(negedge CLK);
    bus.start_valid = 1'b0;
    repeat (7) @(negedge CLK);
    RESET           = 1'b1;
    bus.abort       = 1'b1;
    bus.start_valid = 1'b1;
    @(negedge CLK);
    RESET           = 1'b0;
    bus.abort       = 1'b0;
    bus.start_valid = 1'b0;
    chk("midreset_ready", 32'(bus.start_ready), 32'd1);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_done", 32'(bus.done), 32'd0);
    chk("midreset_count", 32'(bus.match_count), 32'd0);
    chk("midreset_match", 32'(bus.match_pulse), 32'd0);
    run_scan(16'hD000, 4'b1101, -1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      rp = 4'($urandom);
      rd = ($urandom_range(0, 1) == 1) ? {4{rp}} ^ WIDTH'(1 << $urandom_range(0, WIDTH-1))
                                       : WIDTH'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH-1)) : -1;
      run_scan(rd, rp, ab, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
